// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_access_width_e;

    // Width is kept as raw bits so the illegal 2'b11 code can be latched and flagged.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        logic        is_store;
        logic        is_load;
        logic        is_load_unsigned;
    } dmem_req_t;

    function automatic logic req_is_illegal(input logic [1:0] width,
                                            input logic       is_store,
                                            input logic       is_load,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = (width == 2'b11) || (is_store && is_load);
        if (width == MEM_HALF && addr_lo[0])
            bad = 1'b1;
        if (width == MEM_WORD && addr_lo != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [3:0] store_byte_en(input logic [1:0] width,
                                                 input logic [1:0] addr_lo);
        logic [3:0] be;
        case (width)
            MEM_BYTE: be = 4'b0001 << addr_lo;
            MEM_HALF: be = 4'b0011 << addr_lo;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    // Narrow stores are replicated across lanes; byte enables pick the live lane.
    function automatic logic [31:0] store_lane_data(input logic [1:0]  width,
                                                    input logic [31:0] wdata);
        logic [31:0] d;
        case (width)
            MEM_BYTE: d = {4{wdata[7:0]}};
            MEM_HALF: d = {2{wdata[15:0]}};
            default:  d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] format_load(input logic [31:0] rdata,
                                                input logic [1:0]  width,
                                                input logic [1:0]  addr_lo,
                                                input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (addr_lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (width)
            MEM_BYTE: res = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            MEM_HALF: res = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            default:  res = rdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Byte-enabled single-port SRAM with a registered read port; contents are never reset.
module dmem_sram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    // Byte-masked write and synchronous read on every enabled cycle.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b])
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed latency, error pulses for bad requests.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting down; SRAM access issued when counter is 1
// RESP  | one-cycle response pulse
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_width,
    input  logic        req_is_store,
    input  logic        req_is_load,
    input  logic        req_is_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    if (LATENCY < 2 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be within 2..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dmem_req_t   req_q, req_d, req_in;
    logic        accept;
    logic        err_in, err_lat;
    logic        sram_en;
    logic [31:0] sram_rdata;
    logic        unused_addr_hi;

    assign req_in = '{addr:             req_addr,
                      wdata:            req_wdata,
                      width:            req_width,
                      is_store:         req_is_store,
                      is_load:          req_is_load,
                      is_load_unsigned: req_is_unsigned};

    assign accept  = req_valid && (state_q == IDLE) && (req_is_load || req_is_store);
    assign err_in  = req_is_illegal(req_in.width, req_in.is_store, req_in.is_load, req_in.addr[1:0]);
    assign err_lat = req_is_illegal(req_q.width, req_q.is_store, req_q.is_load, req_q.addr[1:0]);

    assign unused_addr_hi = ^req_q.addr[31:ADDR_W+2];

    // Request latch: captured only on accept, held through WAIT and RESP.
    always_comb begin
        req_d = req_q;
        if (accept)
            req_d = req_in;
    end

    // State, countdown and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // Next-state logic; bad requests skip the wait and answer on the next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (err_in) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1)
                    state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sram_en = (state_q == WAIT) && (cnt_q == 4'd1) && !err_lat;

    dmem_sram #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk     (clk),
        .en_i    (sram_en),
        .we_i    (req_q.is_store),
        .be_i    (store_byte_en(req_q.width, req_q.addr[1:0])),
        .addr_i  (req_q.addr[ADDR_W+1:2]),
        .wdata_i (store_lane_data(req_q.width, req_q.wdata)),
        .rdata_o (sram_rdata)
    );

    // Outputs decoded from state; data and error stay zero outside the RESP pulse.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_error = 1'b0;
        resp_rdata = 32'd0;
        if (state_q == RESP) begin
            resp_error = err_lat;
            if (!err_lat && req_q.is_load)
                resp_rdata = format_load(sram_rdata, req_q.width, req_q.addr[1:0],
                                         req_q.is_load_unsigned);
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the memory-access stage; that stage is the initiator.
- Accepts one load/store request at a time through a valid/ready handshake and performs byte/half/word access on a byte-enabled SRAM.
- Returns load data sign- or zero-extended in write-back format, after a fixed, parameterised latency.
- Flags misaligned or illegal requests without touching memory.

Parameters:
- ADDR_W, 10, word-address width; memory depth is 2^ADDR_W 32-bit words.
- LATENCY, 2, cycles from request accept to resp_valid for legal requests; legal range 2..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address (the ALU result).
- req_wdata  in  32  store data; the low bytes are used for byte/half stores.
- req_width  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_is_store  in  1  store request.
- req_is_load  in  1  load request.
- req_is_unsigned  in  1  zero-extend load data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  formatted load data; 0 for stores and errors.
- resp_error  out  1  qualified by resp_valid; misaligned or illegal request.

Behaviour:
- Reset (asserted asynchronously):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, counter=0.
  - SRAM contents are not reset.
- Handshake:
  - A transaction is accepted in cycle T when req_valid && req_ready && (req_is_load || req_is_store).
  - req_valid with both flags low is a no-op: not accepted, no response.
  - req_ready=1 only in IDLE.
- Request latch: addr, wdata, width and flags are registered at the end of cycle T.
- Error detection (from the latched request):
  - width==11; both is_load and is_store set.
  - half with addr[0]==1; word with addr[1:0]!=0.
  - Error path: resp_valid=1, resp_error=1, resp_rdata=0 at T+1. No SRAM access is issued.
- FSM:
  - IDLE -(accept)-> WAIT with counter=LATENCY-1.
  - WAIT decrements the counter each cycle; when counter==1 the SRAM access is issued from the latched request (cycle T+LATENCY-1).
  - WAIT -(counter reaches 0)-> RESP at T+LATENCY.
  - RESP drives resp_valid for exactly one cycle, then returns to IDLE.
  - Error requests go IDLE->RESP directly.
  - The next request is accepted at the earliest in the cycle after RESP (T+LATENCY+1).
- SRAM access:
  - Word index is addr[ADDR_W+1:2]; upper address bits are ignored, so addresses alias and wrap.
  - Store byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - Write data is replicated into lanes: the byte is placed on all 4 lanes, the half on both halves.
  - Reads are synchronous with 1-cycle latency; data is captured into resp_rdata at the RESP cycle.
- Load formatting:
  - Select lane by addr[1:0] (half by addr[1]).
  - Sign-extend bit 7/15 unless req_is_unsigned.
  - Word loads ignore req_is_unsigned.
- Store response: resp_valid=1, resp_error=0, resp_rdata=0.
- resp_rdata/resp_error are held at 0 whenever resp_valid=0.
- Reset mid-operation:
  - Aborts and returns to IDLE; no response is produced.
  - A store whose issue cycle has not yet passed is not written. A write issued before the reset edge may have completed.
- Request inputs are ignored outside IDLE. The initiator must hold them stable only until the accept cycle.

Decomposition:
- BasicTypes gets a MemAccessWidth enum: MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10.
- PipelineTypes gets a DMemReq packed struct: addr, wdata, width, isStore, isLoad, isLoadUnsigned. It is used for the request latch.
- The state enum (IDLE, WAIT, RESP) stays local to the module.
- One sub-module: dmem_sram, a 2^ADDR_W x 32 array with 4-bit byte-enable write and 1-cycle synchronous read; no reset.

Test Plan:
- Word store then load:
  - Store addr=0x10, wdata=0xDEADBEEF, width=10. Expect resp_valid at T+2 with rdata=0, error=0.
  - Load addr=0x10. Expect rdata=0xDEADBEEF at T+2.
- Byte lanes and sign extension:
  - Store byte 0x80 at addr 0x23.
  - Signed byte load at 0x23 -> 0xFFFFFF80; unsigned -> 0x00000080.
  - Word load at 0x20 -> 0x80xxxxxx, with the other bytes unchanged.
- Half store then loads:
  - Store half 0x1234 at 0x32.
  - Word load at 0x30 -> 0x1234xxxx.
  - Half load at 0x32 unsigned -> 0x00001234; signed store/load of 0x8001 -> 0xFFFF8001.
- Misaligned/illegal requests:
  - Word load at 0x41 -> resp_error=1 at T+1, rdata=0.
  - Half store at 0x43 -> error, and a follow-up word load at 0x40 shows memory unchanged.
  - width=11 and both flags set -> error.
- Handshake/latency:
  - LATENCY=4; back-to-back req_valid. req_ready is low T+1..T+4, resp at T+4, second accept at T+5.
  - req_valid with no load/store flag -> no response.
- Reset mid-operation:
  - Assert rst_n low at T+1 of a store with LATENCY=4.
  - Expect outputs 0 and req_ready=1 immediately; no resp_valid.
  - A subsequent load at that address returns the old value.
